// File: rtl/seg7_capture.sv
// seg7_capture: recovers a hex digit from an active-low 7-segment pattern bus.
// A pattern is accepted once it has been sampled unchanged on STABLE_CYCLES
// consecutive edges. Legal digits update the digit/history outputs, BLANK
// only clears valid, and any other pattern is reported as an error.
module seg7_capture #(
  parameter int STABLE_CYCLES = 4,
  parameter int DIGITS        = 4
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [0:6]            leds,
  output logic [3:0]            hexadecimal,
  output logic                  valid,
  output logic                  new_digit,
  output logic                  error,
  output logic [4*DIGITS-1:0]   history,
  output logic [7:0]            err_count
);

  typedef enum logic [1:0] {
    SETTLE = 2'd0,
    ACCEPT = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);
  localparam logic [6:0] BLANK_PAT  = 7'b1111111;

  // Returns {is_digit, is_blank, value}; bit order is a..g from MSB to LSB.
  function automatic logic [5:0] decode_pattern(input logic [6:0] p);
    logic [5:0] r;
    case (p)
      7'b0000001: r = {2'b10, 4'h0};
      7'b1001111: r = {2'b10, 4'h1};
      7'b0010010: r = {2'b10, 4'h2};
      7'b0000110: r = {2'b10, 4'h3};
      7'b1001100: r = {2'b10, 4'h4};
      7'b0100100: r = {2'b10, 4'h5};
      7'b0100000: r = {2'b10, 4'h6};
      7'b0001111: r = {2'b10, 4'h7};
      7'b0000000: r = {2'b10, 4'h8};
      7'b0000100: r = {2'b10, 4'h9};
      7'b0001000: r = {2'b10, 4'hA};
      7'b1100000: r = {2'b10, 4'hB};
      7'b0110001: r = {2'b10, 4'hC};
      7'b1000010: r = {2'b10, 4'hD};
      7'b0110000: r = {2'b10, 4'hE};
      7'b0111000: r = {2'b10, 4'hF};
      7'b1111111: r = {2'b01, 4'h0};
      default:    r = {2'b00, 4'h0};
    endcase
    return r;
  endfunction

  logic [6:0]          leds_s;
  logic [6:0]          samp_q, samp_d;
  logic [7:0]          cnt_q, cnt_d;
  state_t              state_q, state_d;
  logic [3:0]          hex_q, hex_d;
  logic                valid_q, valid_d;
  logic                new_digit_q, new_digit_d;
  logic                error_q, error_d;
  logic [4*DIGITS-1:0] history_q, history_d;
  logic [7:0]          err_count_q, err_count_d;
  logic                changed_s;
  logic                accept_s;
  logic [5:0]          dec_s;

  assign leds_s = leds;

  // Stability tracking, FSM next state and acceptance side effects.
  always_comb begin
    samp_d      = leds_s;
    cnt_d       = cnt_q;
    state_d     = state_q;
    hex_d       = hex_q;
    valid_d     = valid_q;
    new_digit_d = 1'b0;
    error_d     = 1'b0;
    history_d   = history_q;
    err_count_d = err_count_q;
    changed_s   = (leds_s != samp_q);
    dec_s       = decode_pattern(leds_s);

    if (changed_s) begin
      cnt_d = 8'd1;
    end else if (cnt_q >= STABLE_MAX) begin
      cnt_d = STABLE_MAX;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end

    // Only the edge that brings the count up to the threshold accepts.
    accept_s = !changed_s && (state_q == SETTLE) && (cnt_q == (STABLE_MAX - 8'd1));

    case (state_q)
      SETTLE: begin
        if (changed_s) begin
          state_d = SETTLE;
        end else if (accept_s) begin
          state_d = ACCEPT;
        end else begin
          state_d = SETTLE;
        end
      end
      ACCEPT: begin
        if (changed_s) begin
          state_d = SETTLE;
        end else begin
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (changed_s) begin
          state_d = SETTLE;
        end else begin
          state_d = LOCKED;
        end
      end
      default: state_d = SETTLE;
    endcase

    if (accept_s) begin
      if (dec_s[5]) begin
        hex_d       = dec_s[3:0];
        valid_d     = 1'b1;
        new_digit_d = 1'b1;
        history_d   = {history_q[4*DIGITS-5:0], dec_s[3:0]};
      end else if (dec_s[4]) begin
        valid_d = 1'b0;
      end else begin
        valid_d = 1'b0;
        error_d = 1'b1;
        if (err_count_q != 8'hFF) begin
          err_count_d = err_count_q + 8'd1;
        end else begin
          err_count_d = err_count_q;
        end
      end
    end else begin
      valid_d = valid_q;
    end
  end

  // State and output registers; reset wins over any acceptance on the same edge.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      samp_q      <= BLANK_PAT;
      cnt_q       <= 8'd0;
      state_q     <= SETTLE;
      hex_q       <= 4'h0;
      valid_q     <= 1'b0;
      new_digit_q <= 1'b0;
      error_q     <= 1'b0;
      history_q   <= '0;
      err_count_q <= 8'd0;
    end else begin
      samp_q      <= samp_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      hex_q       <= hex_d;
      valid_q     <= valid_d;
      new_digit_q <= new_digit_d;
      error_q     <= error_d;
      history_q   <= history_d;
      err_count_q <= err_count_d;
    end
  end

  assign hexadecimal = hex_q;
  assign valid       = valid_q;
  assign new_digit   = new_digit_q;
  assign error       = error_q;
  assign history     = history_q;
  assign err_count   = err_count_q;

endmodule

// File: doc/seg7_capture.md
Name: seg7_capture

Overview:
- Reverse path of the hex-to-7-segment encoder: samples an active-low 7-segment pattern bus and recovers the 4-bit hex digit.
- Accepts a pattern only after it has been stable for a programmable number of clock edges, and flags patterns that are not valid digits.
- Keeps a shift history of the last DIGITS accepted digits and an error counter.
- Used to monitor or readback display drivers in lab designs and as a self-check on the encoder.

Parameters:
- STABLE_CYCLES, 4: consecutive identical samples required before acceptance. Legal range 2..255.
- DIGITS, 4: number of nibbles held in the history register.

Ports:
- Clock  input  1  system clock, rising edge.
- Reset  input  1  synchronous, active-high.
- leds  input  [0:6]  active-low segments; leds[0]=a … leds[6]=g.
- hexadecimal  output  [3:0]  last accepted digit.
- valid  output  1  hexadecimal holds a decoded digit.
- new_digit  output  1  one-cycle pulse on each valid acceptance.
- error  output  1  one-cycle pulse on acceptance of an illegal pattern.
- history  output  [4*DIGITS-1:0]  accepted digits; newest in [3:0].
- err_count  output  [7:0]  illegal acceptances, saturating at 255.

Behaviour:
- Decode table (leds[0:6], hex value):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000
  - 1111111 = BLANK, a legal idle pattern.
  - Any other pattern is ILLEGAL.
- Sampling:
  - leds is registered into samp on every edge.
  - Stability counter cnt (8 bits): reset to 1 when the newly sampled value differs from samp; otherwise incremented, saturating at STABLE_CYCLES.
- FSM states and transitions:
  - SETTLE: cnt < STABLE_CYCLES.
  - ACCEPT: single cycle, entered on the edge where cnt reaches STABLE_CYCLES.
  - LOCKED: pattern unchanged since acceptance.
  - A changed sample in any state → SETTLE.
  - LOCKED with the same pattern never re-accepts, regardless of hold length.
- Acceptance edge: a pattern present across STABLE_CYCLES consecutive rising edges updates outputs at the last of those edges; no further latency.
  - Legal digit: hexadecimal ← value; valid ← 1; new_digit = 1 for that cycle; history ← {history[4*DIGITS-5:0], value}.
  - BLANK: valid ← 0; hexadecimal, history and err_count unchanged; no pulses.
  - ILLEGAL: valid ← 0; error = 1 for that cycle; err_count increments, holding at 255; hexadecimal and history unchanged.
- Between acceptances:
  - hexadecimal and valid hold their last values.
  - new_digit and error are 0.
- Glitch filtering: any differing sample, including a single cycle of another pattern, restarts the count. Shorter events are discarded silently.
- Reset (synchronous, active-high):
  - All outputs 0, history 0, err_count 0.
  - samp = 1111111, cnt = 0, state SETTLE.
  - Reset mid-count abandons the partial count.
  - A pattern present across reset needs STABLE_CYCLES edges after reset deasserts to be accepted.
- Reset priority: Reset has priority over acceptance on the same edge.
- Counter width: cnt is 8 bits.

Test Plan:
1. Reset, then hold 0010010 for 6 cycles → after 4th edge: hexadecimal=2, valid=1, new_digit high exactly 1 cycle, history=0x0002. No further pulse.
2. Digits 1,2,3,4,5, each held 5 cycles → five new_digit pulses, history=0x2345, hexadecimal=5.
3. 0000110 for 3 cycles, 1001111 for 1 cycle, 0000110 for 4 cycles → only one acceptance (3), at the final 4th edge. The 1-cycle "1" is never accepted.
4. 1111110 held 20 cycles → one error pulse, err_count=1, valid=0, history unchanged. Then BLANK held 4 cycles → valid=0, no pulses.
5. 300 alternations of ILLEGAL (4 cycles) and BLANK (4 cycles) → err_count=255 and stays 255; error still pulses each time.
6. Reset asserted for 1 cycle after 3 stable cycles of 0001000 → all outputs 0. Acceptance of A occurs only on the 4th edge after reset deasserts.
7. Sweep all 16 table entries through the hex-to-7-segment encoder into this block → hexadecimal equals the encoder input for every value.
